// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel tick/level outputs with
// wrap-synchronised divisor updates, a global run gate, phase-align clear and an LED heartbeat.
module clock_enable_gen #(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 28,
  parameter int DIV_RST = 2,
  parameter int HB_W    = 28,
  parameter int LED_W   = 4,
  localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              run,
  input  logic              sync_clear,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_value,
  output logic [N_CH-1:0]   ch_tick,
  output logic [N_CH-1:0]   ch_level,
  output logic [N_CH-1:0]   div_pending,
  output logic [LED_W-1:0]  led_clock
);

  localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);

  logic [HB_W-1:0] hb;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) hb <= '0;
    else       hb <= hb + HB_W'(1);
  end

  assign led_clock = hb[HB_W-1 -: LED_W];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shadow;
    logic             tick_r;
    logic             level_r;
    logic             pend_r;
    logic             wr_hit;
    logic             at_end;
    logic             copy;

    // Selects at or above N_CH can never match a channel index, so such writes vanish.
    assign wr_hit = div_wr && (div_sel == SEL_W'(i));
    assign at_end = (div != '0) && (cnt == div - DIV_W'(1));
    // A disabled channel adopts its pending divisor at once; a running one only at its wrap.
    assign copy   = pend_r && ((div == '0) || (run && at_end));

    always_ff @(posedge clock_50 or posedge reset) begin
      if (reset) begin
        cnt     <= '0;
        div     <= DIV_RST_V;
        shadow  <= '0;
        tick_r  <= 1'b0;
        level_r <= 1'b0;
        pend_r  <= 1'b0;
      end else if (sync_clear) begin
        cnt     <= '0;
        tick_r  <= 1'b0;
        level_r <= 1'b0;
        pend_r  <= 1'b0;
        if (wr_hit) begin
          div    <= div_value;
          shadow <= div_value;
        end else if (pend_r) begin
          div <= shadow;
        end
      end else begin
        tick_r <= 1'b0;
        if (copy) begin
          div    <= shadow;
          pend_r <= 1'b0;
        end
        if (run && at_end) begin
          cnt     <= '0;
          tick_r  <= 1'b1;
          level_r <= ~level_r;
        end else if (run && (div != '0)) begin
          cnt <= cnt + DIV_W'(1);
        end
        // A write landing on the wrap edge waits for the following wrap.
        if (wr_hit) begin
          shadow <= div_value;
          pend_r <= 1'b1;
        end
      end
    end

    assign ch_tick[i]     = tick_r;
    assign ch_level[i]    = level_r;
    assign div_pending[i] = pend_r;
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: a default 4-channel instance and a narrow 3-channel instance
// (4-bit divisors, 6-bit heartbeat) share stimulus and are checked against an abstract model.
module tb_clock_enable_gen;

  logic        clock_50   = 1'b0;
  logic        reset      = 1'b1;
  logic        run        = 1'b1;
  logic        sync_clear = 1'b0;
  logic        div_wr     = 1'b0;
  logic [1:0]  div_sel    = 2'd0;
  logic [27:0] div_value  = 28'd0;

  logic [3:0] tick_a, level_a, pend_a, led_a;
  logic [2:0] tick_b, level_b, pend_b;
  logic [1:0] led_b;

  clock_enable_gen #(.N_CH(4), .DIV_W(28), .DIV_RST(2), .HB_W(28), .LED_W(4)) dut_a (
    .clock_50(clock_50), .reset(reset), .run(run), .sync_clear(sync_clear),
    .div_wr(div_wr), .div_sel(div_sel), .div_value(div_value),
    .ch_tick(tick_a), .ch_level(level_a), .div_pending(pend_a), .led_clock(led_a));

  clock_enable_gen #(.N_CH(3), .DIV_W(4), .DIV_RST(3), .HB_W(6), .LED_W(2)) dut_b (
    .clock_50(clock_50), .reset(reset), .run(run), .sync_clear(sync_clear),
    .div_wr(div_wr), .div_sel(div_sel), .div_value(div_value[3:0]),
    .ch_tick(tick_b), .ch_level(level_b), .div_pending(pend_b), .led_clock(led_b));

  always #5 clock_50 = ~clock_50;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: period length, enabled cycles elapsed in the current period, staged divisor.
  int     m_n[2][4];
  int     m_prog[2][4];
  int     m_sh[2][4];
  bit     m_lv[2][4];
  bit     m_pd[2][4];
  bit     m_tk[2][4];
  longint m_hb;

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        m_n[k][c] = (k == 0) ? 2 : 3;
        m_prog[k][c] = 0; m_sh[k][c] = 0;
        m_lv[k][c] = 0; m_pd[k][c] = 0; m_tk[k][c] = 0;
      end
    m_hb = 0;
  endfunction

  function automatic void model_edge();
    int v;
    bit hit, moved;
    if (reset) begin
      model_reset();
      return;
    end
    m_hb++;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < nch(k); c++) begin
        v   = (k == 0) ? int'(div_value) : int'(div_value) % 16;
        hit = div_wr && (int'(div_sel) == c);
        m_tk[k][c] = 0;
        if (sync_clear) begin
          m_prog[k][c] = 0; m_lv[k][c] = 0;
          if (hit) begin m_n[k][c] = v; m_sh[k][c] = v; end
          else if (m_pd[k][c]) m_n[k][c] = m_sh[k][c];
          m_pd[k][c] = 0;
        end else begin
          moved = 0;
          if (m_n[k][c] == 0) begin
            if (m_pd[k][c]) begin m_n[k][c] = m_sh[k][c]; moved = 1; end
          end else if (run) begin
            m_prog[k][c]++;
            if (m_prog[k][c] == m_n[k][c]) begin
              m_prog[k][c] = 0; m_tk[k][c] = 1; m_lv[k][c] = !m_lv[k][c];
              if (m_pd[k][c]) begin m_n[k][c] = m_sh[k][c]; moved = 1; end
            end
          end
          if (moved) m_pd[k][c] = 0;
          if (hit) begin m_sh[k][c] = v; m_pd[k][c] = 1; end
        end
      end
  endfunction

  function automatic logic [31:0] exp_bits(int k, int what);
    logic [31:0] r = '0;
    for (int c = 0; c < nch(k); c++)
      case (what)
        0:       r[c] = m_tk[k][c];
        1:       r[c] = m_lv[k][c];
        default: r[c] = m_pd[k][c];
      endcase
    return r;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic void compare_all();
    check("tick_a",  32'(tick_a),  exp_bits(0, 0));
    check("level_a", 32'(level_a), exp_bits(0, 1));
    check("pend_a",  32'(pend_a),  exp_bits(0, 2));
    check("led_a",   32'(led_a),   32'((m_hb >> 24) % 16));
    check("tick_b",  32'(tick_b),  exp_bits(1, 0));
    check("level_b", 32'(level_b), exp_bits(1, 1));
    check("pend_b",  32'(pend_b),  exp_bits(1, 2));
    check("led_b",   32'(led_b),   32'((m_hb % 64) >> 4));
  endfunction

  task automatic step();
    @(posedge clock_50);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cyc(bit r, bit sc, bit wr, int sel, int val);
    run = r; sync_clear = sc; div_wr = wr;
    div_sel = 2'(sel); div_value = 28'(val);
    step();
    sync_clear = 1'b0; div_wr = 1'b0;
  endtask

  typedef struct {
    bit         wr;
    int         sel;
    int         val;
    logic [3:0] tick;
    logic [3:0] level;
    logic [3:0] pend;
  } vec_t;

  vec_t vt[14];

  initial begin
    int v;
    // Cycle n = n-th edge after reset release, run held high, ch1 written with 5 at cycle 3.
    vt[0]  = '{0, 0, 0, 4'h0, 4'h0, 4'h0};
    vt[1]  = '{0, 0, 0, 4'hF, 4'hF, 4'h0};
    vt[2]  = '{1, 1, 5, 4'h0, 4'hF, 4'h2};
    vt[3]  = '{0, 0, 0, 4'hF, 4'h0, 4'h0};
    vt[4]  = '{0, 0, 0, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{0, 0, 0, 4'hD, 4'hD, 4'h0};
    vt[6]  = '{0, 0, 0, 4'h0, 4'hD, 4'h0};
    vt[7]  = '{0, 0, 0, 4'hD, 4'h0, 4'h0};
    vt[8]  = '{0, 0, 0, 4'h2, 4'h2, 4'h0};
    vt[9]  = '{0, 0, 0, 4'hD, 4'hF, 4'h0};
    vt[10] = '{0, 0, 0, 4'h0, 4'hF, 4'h0};
    vt[11] = '{0, 0, 0, 4'hD, 4'h2, 4'h0};
    vt[12] = '{0, 0, 0, 4'h0, 4'h2, 4'h0};
    vt[13] = '{0, 0, 0, 4'hF, 4'hD, 4'h0};

    model_reset();
    for (int i = 0; i < 3; i++) step();
    check("rst_tick",  32'(tick_a),  32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_led",   32'(led_a),   32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cyc(1, 0, vt[i].wr, vt[i].sel, vt[i].val);
      check($sformatf("vec%0d_tick", i + 1),  32'(tick_a),  32'(vt[i].tick));
      check($sformatf("vec%0d_level", i + 1), 32'(level_a), 32'(vt[i].level));
      check($sformatf("vec%0d_pend", i + 1),  32'(pend_a),  32'(vt[i].pend));
    end

    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 19) == 0) ? 0 : (($urandom_range(0, 19) == 0) ? 15 : $urandom_range(1, 6));
      cyc($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 15,
          $urandom_range(0, 3), v);
    end

    // Freeze with ch0 one enabled cycle from its wrap.
    cyc(1, 1, 1, 0, 3);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("frozen_tick0", 32'(tick_a[0]), 32'd0);
    end
    cyc(1, 0, 0, 0, 0);
    check("resume_tick0", 32'(tick_a[0]), 32'd1);

    // sync_clear on ch0's wrap edge, with a coincident write to ch3.
    cyc(1, 1, 1, 0, 2);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 3, 7);
    check("sc_tick",  32'(tick_a),  32'd0);
    check("sc_level", 32'(level_a), 32'd0);
    check("sc_pend",  32'(pend_a),  32'd0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("sc_ch3_tick", 32'(tick_a[3]), 32'(i == 7));
    end

    // Disable ch2, then re-enable with 4.
    cyc(1, 0, 1, 2, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("dis_tick2", 32'(tick_a[2]), 32'd0);
    end
    cyc(1, 0, 1, 2, 4);
    check("en_pend2", 32'(pend_a[2]), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("en_tick2", 32'(tick_a[2]), 32'(i == 5));
    end

    // Reset mid-period with a pending write.
    cyc(1, 0, 1, 1, 9);
    cyc(1, 0, 0, 0, 0);
    @(posedge clock_50);
    model_edge();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_tick",  32'(tick_a), 32'd0);
    check("arst_level", 32'({level_a, 1'b0, level_b}), 32'd0);
    check("arst_pend",  32'({pend_a, 1'b0, pend_b}), 32'd0);
    check("arst_led_b", 32'(led_b), 32'd0);
    compare_all();
    step();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i == 15) check("hb_led_b15", 32'(led_b), 32'd0);
      if (i == 16) check("hb_led_b16", 32'(led_b), 32'd1);
    end

    // All-ones divisor on the 4-bit instance: period 15.
    cyc(1, 1, 1, 0, 15);
    for (int i = 1; i <= 31; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (i == 14) check("max_b_tick14", 32'(tick_b[0]), 32'd0);
      if (i == 15) check("max_b_tick15", 32'(tick_b[0]), 32'd1);
      if (i == 30) check("max_b_tick30", 32'(tick_b[0]), 32'd1);
    end
    for (int i = 0; i < 70; i++) cyc(1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
